reg_bank_reader: RTL and testbench

Read-side responder for a small register bank whose entries are written by a single-cycle write port. It sits behind the task-driven write path, serving read requests through a two-stage valid/ready pipeline. Responses carry data and an out-of-range error flag, and are returned in request order. Writes are accepted on every cycle independently of reads, with write-first forwarding into a read in flight.

---
 rtl/reg_bank_reader_if.sv | 36 +++
 rtl/reg_bank_reader_store.sv | 61 ++++++
 rtl/reg_bank_reader.sv | 128 ++++++++++++
 tb/tb_reg_bank_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_reader_if.sv
// Bus bundle for reg_bank_reader: single-cycle write port, read request
// channel, read response channel and the in-flight request count.
interface reg_bank_reader_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  // Write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  // Read request channel
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  // Read response channel
  logic              rd_rsp_valid;
  logic              rd_rsp_ready;
  logic [WIDTH-1:0]  rd_rsp_data;
  logic              rd_rsp_err;
  // Requests accepted but not yet consumed
  logic [1:0]        rd_pending;

  // Requester / writer side
  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_req_valid, rd_req_addr, rd_rsp_ready,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err, rd_pending
  );

  // Register bank side
  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_req_valid, rd_req_addr, rd_rsp_ready,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err, rd_pending
  );
endinterface

// File: rtl/reg_bank_reader_store.sv
// reg_bank_store: DEPTH x WIDTH register array with a single-cycle write
// port that silently drops out-of-range addresses, and an asynchronous read
// port that returns 0 for out-of-range addresses.
module reg_bank_store #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  // DEPTH widened by one bit so the range compare also works when
  // DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_in_range;
  logic             rd_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  // Write decode: update one entry, ignore addresses beyond the array.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    mem_d = mem_q;
    if (wr_en && wr_in_range) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage register array with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is made of flops rather than a RAM macro, so it can
      // be cleared on reset; a RAM-style array would not allow this.
      mem_q <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignment so all flops update together at the
      // edge and readers in the same cycle see the old value.
      mem_q <= mem_d;
    end
  end

  // Asynchronous read port; out-of-range addresses read as 0.
  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/reg_bank_reader.sv
// reg_bank_reader: read-side responder for a small register bank.
// Two-stage valid/ready pipeline (S1 = address, S2 = response) in front of
// reg_bank_store, with write-first forwarding into the S1 -> S2 transfer,
// an out-of-range error flag and a count of requests in flight.
module reg_bank_reader #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  reg_bank_reader_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  // S1 (address stage)
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
  // S2 (response stage)
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;
  // In-flight request count
  logic [1:0]        pending_q,   pending_d;

  logic              s2_adv;
  logic              req_ready;
  logic              req_acc;
  logic              rsp_cons;
  logic              s1_in_range;
  logic              fwd_hit;
  logic [WIDTH-1:0]  store_rd_data;

  reg_bank_store #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (s1_addr_q),
    .rd_data (store_rd_data)
  );

  // Handshake: S2 can take new data when empty or being drained; S1 can
  // take a request when empty or when it is moving into S2. Neither term
  // looks at rd_req_valid.
  assign s2_adv      = !rsp_valid_q || bus.rd_rsp_ready;
  assign req_ready   = !s1_valid_q || s2_adv;
  assign req_acc     = bus.rd_req_valid && req_ready;
  assign rsp_cons    = rsp_valid_q && bus.rd_rsp_ready;
  assign s1_in_range = ({1'b0, s1_addr_q} < DEPTH_W);
  // A write landing on the same edge as the transfer wins over the array.
  assign fwd_hit     = bus.wr_en && (bus.wr_addr == s1_addr_q);

  // S1 next state: load on accept, empty when it moves on with no refill.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    if (req_ready) begin
      s1_valid_d = bus.rd_req_valid;
      if (bus.rd_req_valid) begin
        s1_addr_d = bus.rd_req_addr;
      end
    end
  end

  // S2 next state: capture S1 with range check and forwarding; hold while
  // stalled so the presented response never changes under backpressure.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (s2_adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (!s1_in_range) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else if (fwd_hit) begin
          rsp_data_d = bus.wr_data;
          rsp_err_d  = 1'b0;
        end else begin
          rsp_data_d = store_rd_data;
          rsp_err_d  = 1'b0;
        end
      end
    end
  end

  // Pending count: +1 on accept, -1 on consume, unchanged when both.
  always_comb begin
    pending_d = pending_q + 2'(req_acc) - 2'(rsp_cons);
  end

  // Pipeline and counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      pending_q   <= 2'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      pending_q   <= pending_d;
    end
  end

  // Only S1 and S2 can hold requests, so the count never exceeds 2.
  a_pending_max : assert property (@(posedge clk) disable iff (rst) pending_q <= 2'd2);

  assign bus.rd_req_ready = req_ready;
  assign bus.rd_rsp_valid = rsp_valid_q;
  assign bus.rd_rsp_data  = rsp_data_q;
  assign bus.rd_rsp_err   = rsp_err_q;
  assign bus.rd_pending   = pending_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Testbench for reg_bank_reader: a DEPTH=8 instance driven by a vector table
// and directed sequences, plus a DEPTH=6 instance on the same stimulus for
// the out-of-range cases.
module tb_reg_bank_reader;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_req_valid;
  logic [2:0] rd_req_addr;
  logic       rd_rsp_ready;

  int n_tests;
  int n_fail;

  reg_bank_reader_if #(.WIDTH(8), .ADDR_W(3)) if8 ();
  reg_bank_reader_if #(.WIDTH(8), .ADDR_W(3)) if6 ();

  assign if8.wr_en        = wr_en;
  assign if8.wr_addr      = wr_addr;
  assign if8.wr_data      = wr_data;
  assign if8.rd_req_valid = rd_req_valid;
  assign if8.rd_req_addr  = rd_req_addr;
  assign if8.rd_rsp_ready = rd_rsp_ready;
  assign if6.wr_en        = wr_en;
  assign if6.wr_addr      = wr_addr;
  assign if6.wr_data      = wr_data;
  assign if6.rd_req_valid = rd_req_valid;
  assign if6.rd_req_addr  = rd_req_addr;
  assign if6.rd_rsp_ready = rd_rsp_ready;

  reg_bank_reader #(.DEPTH(8), .WIDTH(8), .ADDR_W(3)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  reg_bank_reader #(.DEPTH(6), .WIDTH(8), .ADDR_W(3)) u6 (
    .clk (clk),
    .rst (rst),
    .bus (if6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       rv;
    logic [2:0] ra;
    logic       rr;
    logic       e_rreq;   // rd_req_ready before the edge
    logic       e_valid;  // after the edge
    logic [7:0] e_data;
    logic       e_err;
    logic [1:0] e_pend;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic we, logic [2:0] wa, logic [7:0] wd,
                              logic rv, logic [2:0] ra, logic rr,
                              logic e_rreq, logic e_valid, logic [7:0] e_data,
                              logic e_err, logic [1:0] e_pend);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rr = rr;
    v.e_rreq = e_rreq; v.e_valid = e_valid; v.e_data = e_data;
    v.e_err = e_err; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic rv, input logic [2:0] ra, input logic rr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_req_valid = rv; rd_req_addr = ra; rd_rsp_ready = rr;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic chk_rsp8(input string tag, input logic e_valid, input logic [7:0] e_data,
                          input logic e_err, input logic [1:0] e_pend);
    check({tag, ".valid"}, 32'(if8.rd_rsp_valid), 32'(e_valid));
    check({tag, ".pend"},  32'(if8.rd_pending),   32'(e_pend));
    if (e_valid) begin
      check({tag, ".data"}, 32'(if8.rd_rsp_data), 32'(e_data));
      check({tag, ".err"},  32'(if8.rd_rsp_err),  32'(e_err));
    end
  endtask

  task automatic chk_rsp6(input string tag, input logic [7:0] e_data, input logic e_err);
    check({tag, ".valid6"}, 32'(if6.rd_rsp_valid), 32'd1);
    check({tag, ".data6"},  32'(if6.rd_rsp_data),  32'(e_data));
    check({tag, ".err6"},   32'(if6.rd_rsp_err),   32'(e_err));
  endtask

  logic [7:0] exp6 [6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    idle();

    // ---- Vector table ----
    // Phase A: read all 8 entries back-to-back after reset; all read 0.
    // In steady streaming one request sits in S1 and one in S2, so the
    // count is 2 until the tail drains.
    vecs[0] = mk(0, 0, 8'h00, 1, 3'd0, 1,  1, 0, 8'h00, 0, 2'd1);
    for (int k = 1; k < 8; k++)
      vecs[k] = mk(0, 0, 8'h00, 1, 3'(k), 1,  1, 1, 8'h00, 0, 2'd2);
    vecs[8] = mk(0, 0, 8'h00, 0, 3'd0, 1,  1, 1, 8'h00, 0, 2'd1);
    vecs[9] = mk(0, 0, 8'h00, 0, 3'd0, 1,  1, 0, 8'h00, 0, 2'd0);
    // Phase B: write 0x30+k to every address.
    for (int k = 0; k < 8; k++)
      vecs[10+k] = mk(1, 3'(k), 8'h30 + 8'(k), 0, 3'd0, 1,  1, 0, 8'h00, 0, 2'd0);
    // Phase C: reads under mixed ready, plus a same-edge forward on addr 6.
    vecs[18] = mk(0, 0, 8'h00, 1, 3'd5, 1,  1, 0, 8'h00, 0, 2'd1);
    vecs[19] = mk(0, 0, 8'h00, 1, 3'd2, 1,  1, 1, 8'h35, 0, 2'd2);
    vecs[20] = mk(0, 0, 8'h00, 1, 3'd6, 0,  0, 1, 8'h35, 0, 2'd2);
    vecs[21] = mk(0, 0, 8'h00, 1, 3'd6, 1,  1, 1, 8'h32, 0, 2'd2);
    vecs[22] = mk(1, 3'd6, 8'hC6, 0, 3'd0, 1,  1, 1, 8'hC6, 0, 2'd1);
    vecs[23] = mk(0, 0, 8'h00, 0, 3'd0, 1,  1, 0, 8'h00, 0, 2'd0);

    // ---- Reset state ----
    tick();
    tick();
    check("rst.valid", 32'(if8.rd_rsp_valid), 32'd0);
    check("rst.data",  32'(if8.rd_rsp_data),  32'd0);
    check("rst.err",   32'(if8.rd_rsp_err),   32'd0);
    check("rst.pend",  32'(if8.rd_pending),   32'd0);
    check("rst.rreq",  32'(if8.rd_req_ready), 32'd1);
    rst = 1'b0;
    tick();

    // ---- Apply table ----
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra, vecs[i].rr);
      #1;
      check($sformatf("v%0d.rreq", i), 32'(if8.rd_req_ready), 32'(vecs[i].e_rreq));
      tick();
      chk_rsp8($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_data,
               vecs[i].e_err, vecs[i].e_pend);
    end

    // ---- Write-first forwarding: 0xA5 to addr 3 as S1(3) transfers ----
    drive(0, 3'd0, 8'h00, 1, 3'd3, 1);
    tick();
    chk_rsp8("fwd.acc", 1'b0, 8'h00, 1'b0, 2'd1);
    drive(1, 3'd3, 8'hA5, 0, 3'd0, 1);
    tick();
    chk_rsp8("fwd.rsp", 1'b1, 8'hA5, 1'b0, 2'd1);
    idle();
    tick();
    chk_rsp8("fwd.drain", 1'b0, 8'h00, 1'b0, 2'd0);

    // ---- DEPTH=6 instance: out-of-range read and write ----
    drive(0, 3'd0, 8'h00, 1, 3'd7, 1);
    tick();
    idle();
    tick();
    chk_rsp6("oor7", 8'h00, 1'b1);
    check("oor7.data8", 32'(if8.rd_rsp_data), 32'h37);
    check("oor7.err8",  32'(if8.rd_rsp_err),  32'd0);
    tick();
    drive(1, 3'd6, 8'h77, 0, 3'd0, 1);
    tick();
    drive(0, 3'd0, 8'h00, 1, 3'd6, 1);
    tick();
    idle();
    tick();
    chk_rsp6("oor6", 8'h00, 1'b1);
    tick();
    exp6[0] = 8'h30; exp6[1] = 8'h31; exp6[2] = 8'h32;
    exp6[3] = 8'hA5; exp6[4] = 8'h34; exp6[5] = 8'h35;
    for (int k = 0; k < 6; k++) begin
      drive(0, 3'd0, 8'h00, 1, 3'(k), 1);
      tick();
      if (k > 0) chk_rsp6($sformatf("arr6.%0d", k - 1), exp6[k-1], 1'b0);
    end
    idle();
    tick();
    chk_rsp6("arr6.5", exp6[5], 1'b0);
    tick();

    // ---- Backpressure: rsp_ready low, three requests ----
    drive(0, 3'd0, 8'h00, 1, 3'd1, 0);
    #1;
    check("bp.r1.rreq", 32'(if8.rd_req_ready), 32'd1);
    tick();
    chk_rsp8("bp.r1", 1'b0, 8'h00, 1'b0, 2'd1);
    drive(0, 3'd0, 8'h00, 1, 3'd2, 0);
    #1;
    check("bp.r2.rreq", 32'(if8.rd_req_ready), 32'd1);
    tick();
    chk_rsp8("bp.r2", 1'b1, 8'h31, 1'b0, 2'd2);
    // Third request is refused; rewrite the entry under the stalled response.
    drive(1, 3'd1, 8'hEE, 1, 3'd4, 0);
    #1;
    check("bp.r3.rreq", 32'(if8.rd_req_ready), 32'd0);
    tick();
    chk_rsp8("bp.hold1", 1'b1, 8'h31, 1'b0, 2'd2);
    drive(0, 3'd0, 8'h00, 1, 3'd4, 0);
    #1;
    check("bp.hold.rreq", 32'(if8.rd_req_ready), 32'd0);
    tick();
    chk_rsp8("bp.hold2", 1'b1, 8'h31, 1'b0, 2'd2);
    // Release: third request goes in as the first response drains.
    drive(0, 3'd0, 8'h00, 1, 3'd4, 1);
    #1;
    check("bp.rel.rreq", 32'(if8.rd_req_ready), 32'd1);
    tick();
    chk_rsp8("bp.d2", 1'b1, 8'h32, 1'b0, 2'd2);
    idle();
    tick();
    chk_rsp8("bp.d3", 1'b1, 8'h34, 1'b0, 2'd1);
    tick();
    chk_rsp8("bp.empty", 1'b0, 8'h00, 1'b0, 2'd0);
    drive(0, 3'd0, 8'h00, 1, 3'd1, 1);
    tick();
    idle();
    tick();
    chk_rsp8("bp.rewr", 1'b1, 8'hEE, 1'b0, 2'd1);
    tick();

    // ---- Asynchronous reset with two requests in flight ----
    drive(0, 3'd0, 8'h00, 1, 3'd1, 0);
    tick();
    drive(0, 3'd0, 8'h00, 1, 3'd3, 0);
    tick();
    chk_rsp8("ar.pre", 1'b1, 8'hEE, 1'b0, 2'd2);
    rst = 1'b1;
    #1;
    check("ar.valid", 32'(if8.rd_rsp_valid), 32'd0);
    check("ar.data",  32'(if8.rd_rsp_data),  32'd0);
    check("ar.err",   32'(if8.rd_rsp_err),   32'd0);
    check("ar.pend",  32'(if8.rd_pending),   32'd0);
    check("ar.rreq",  32'(if8.rd_req_ready), 32'd1);
    idle();
    #1;
    rst = 1'b0;
    tick();
    drive(0, 3'd0, 8'h00, 1, 3'd1, 1);
    tick();
    drive(0, 3'd0, 8'h00, 1, 3'd3, 1);
    tick();
    chk_rsp8("ar.rd1", 1'b1, 8'h00, 1'b0, 2'd2);
    idle();
    tick();
    chk_rsp8("ar.rd3", 1'b1, 8'h00, 1'b0, 2'd1);
    tick();
    chk_rsp8("ar.end", 1'b0, 8'h00, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
